// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 timing defaults and lock-state type for the VGA sync monitor.
package vga_timing_pkg;

  localparam int unsigned POS_W = 10;
  localparam int unsigned ERR_W = 8;

  localparam int unsigned H_VISIBLE_DFLT    = 640;
  localparam int unsigned H_FP_DFLT         = 16;
  localparam int unsigned H_SYNC_DFLT       = 96;
  localparam int unsigned H_BP_DFLT         = 48;
  localparam int unsigned H_TOTAL_DFLT      = H_VISIBLE_DFLT + H_FP_DFLT + H_SYNC_DFLT + H_BP_DFLT;
  localparam int unsigned H_SYNC_START_DFLT = H_VISIBLE_DFLT + H_FP_DFLT;
  localparam int unsigned H_SYNC_END_DFLT   = H_SYNC_START_DFLT + H_SYNC_DFLT;

  localparam int unsigned V_VISIBLE_DFLT    = 480;
  localparam int unsigned V_FP_DFLT         = 10;
  localparam int unsigned V_SYNC_DFLT       = 2;
  localparam int unsigned V_BP_DFLT         = 33;
  localparam int unsigned V_TOTAL_DFLT      = V_VISIBLE_DFLT + V_FP_DFLT + V_SYNC_DFLT + V_BP_DFLT;
  localparam int unsigned V_SYNC_START_DFLT = V_VISIBLE_DFLT + V_FP_DFLT;
  localparam int unsigned V_SYNC_END_DFLT   = V_SYNC_START_DFLT + V_SYNC_DFLT;

  localparam int unsigned LOCK_FRAMES_DFLT  = 2;

  typedef enum logic [1:0] {
    UNLOCKED,
    ACQUIRE,
    LOCKED
  } lock_state_t;

endpackage

// File: rtl/sync_edge_detect.sv
// Normalises a sync input to active-high, double-flops it and flags assert/deassert edges.
module sync_edge_detect #(
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sync_raw,
  output logic assert_edge_c,
  output logic deassert_edge_c
);

  logic q1;
  logic q2;

  // Reset leaves both stages at the deasserted level so no edge fires out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q1 <= 1'b0;
      q2 <= 1'b0;
    end else begin
      q1 <= ACTIVE_LOW ? ~sync_raw : sync_raw;
      q2 <= q1;
    end
  end

  assign assert_edge_c   = q1 & ~q2;
  assign deassert_edge_c = ~q1 & q2;

endmodule

// File: rtl/vga_sync_monitor.sv
// Rebuilds column/row from HSYNC/VSYNC edges, checks geometry, tracks lock and counts errors.
module vga_sync_monitor
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_VISIBLE       = H_VISIBLE_DFLT,
  parameter int unsigned H_FP            = H_FP_DFLT,
  parameter int unsigned H_SYNC          = H_SYNC_DFLT,
  parameter int unsigned H_BP            = H_BP_DFLT,
  parameter int unsigned V_VISIBLE       = V_VISIBLE_DFLT,
  parameter int unsigned V_FP            = V_FP_DFLT,
  parameter int unsigned V_SYNC          = V_SYNC_DFLT,
  parameter int unsigned V_BP            = V_BP_DFLT,
  parameter bit          SYNC_ACTIVE_LOW = 1'b1,
  parameter int unsigned LOCK_FRAMES     = LOCK_FRAMES_DFLT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             HSYNC,
  input  logic             VSYNC,
  output logic [POS_W-1:0] colPos,
  output logic [POS_W-1:0] rowPos,
  output logic             visible,
  output logic             locked,
  output logic             frame_start,
  output logic             h_err,
  output logic             v_err,
  output logic [ERR_W-1:0] err_count
);

  localparam int unsigned H_TOTAL      = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int unsigned H_SYNC_START = H_VISIBLE + H_FP;
  localparam int unsigned H_SYNC_END   = H_SYNC_START + H_SYNC;
  localparam int unsigned V_TOTAL      = V_VISIBLE + V_FP + V_SYNC + V_BP;
  localparam int unsigned V_SYNC_START = V_VISIBLE + V_FP;
  localparam int unsigned V_SYNC_END   = V_SYNC_START + V_SYNC;
  localparam int unsigned TIMEOUT      = 2 * H_TOTAL;
  localparam int unsigned TO_W         = $clog2(TIMEOUT + 1);
  localparam int unsigned GF_W         = $clog2(LOCK_FRAMES + 1);

  logic h_assert_c, h_deassert_c, v_assert_c, v_deassert_c;

  sync_edge_detect #(.ACTIVE_LOW(SYNC_ACTIVE_LOW)) u_hsync_edge (
    .clk             (clk),
    .rst_n           (rst_n),
    .sync_raw        (HSYNC),
    .assert_edge_c   (h_assert_c),
    .deassert_edge_c (h_deassert_c)
  );

  sync_edge_detect #(.ACTIVE_LOW(SYNC_ACTIVE_LOW)) u_vsync_edge (
    .clk             (clk),
    .rst_n           (rst_n),
    .sync_raw        (VSYNC),
    .assert_edge_c   (v_assert_c),
    .deassert_edge_c (v_deassert_c)
  );

  lock_state_t      state, state_nxt;
  logic [GF_W-1:0]  good_frames, good_nxt;
  logic             dirty, dirty_nxt;
  logic             seen_h, seen_h_nxt;
  logic [TO_W-1:0]  to_cnt;
  logic [POS_W-1:0] col_pred_c, row_pred_c, col_nxt_c, row_nxt_c;
  logic             col_wrap_c, checks_on_c, h_err_c, v_err_c, timeout_c;

  // Predicted position (free-running count) versus sync-edge reloads and geometry checks.
  always_comb begin
    col_wrap_c  = (colPos == POS_W'(H_TOTAL - 1));
    col_pred_c  = col_wrap_c ? '0 : colPos + POS_W'(1);
    row_pred_c  = rowPos;
    if (col_wrap_c) begin
      row_pred_c = (rowPos == POS_W'(V_TOTAL - 1)) ? '0 : rowPos + POS_W'(1);
    end
    col_nxt_c   = h_assert_c ? POS_W'(H_SYNC_START) : col_pred_c;
    row_nxt_c   = v_assert_c ? POS_W'(V_SYNC_START) : row_pred_c;
    checks_on_c = (state != UNLOCKED);
    h_err_c     = checks_on_c &&
                  ((h_assert_c   && (col_pred_c != POS_W'(H_SYNC_START))) ||
                   (h_deassert_c && (col_pred_c != POS_W'(H_SYNC_END))));
    v_err_c     = checks_on_c &&
                  ((v_assert_c   && (row_pred_c != POS_W'(V_SYNC_START))) ||
                   (v_deassert_c && (row_pred_c != POS_W'(V_SYNC_END))));
    timeout_c   = !h_assert_c && (to_cnt == TO_W'(TIMEOUT - 1));
  end

  // Lock FSM: a frame counts as good only if no error occurred since the previous VSYNC edge.
  always_comb begin
    state_nxt  = state;
    good_nxt   = good_frames;
    dirty_nxt  = dirty;
    seen_h_nxt = seen_h | h_assert_c;
    unique case (state)
      UNLOCKED: begin
        if (v_assert_c && (seen_h || h_assert_c)) begin
          state_nxt = ACQUIRE;
          good_nxt  = '0;
          dirty_nxt = 1'b0;
        end
      end
      ACQUIRE: begin
        if (h_err_c || v_err_c) begin
          good_nxt  = '0;
          dirty_nxt = 1'b1;
        end else if (v_assert_c) begin
          if (dirty) begin
            dirty_nxt = 1'b0;
          end else if (good_frames + GF_W'(1) == GF_W'(LOCK_FRAMES)) begin
            state_nxt = LOCKED;
            good_nxt  = GF_W'(LOCK_FRAMES);
          end else begin
            good_nxt = good_frames + GF_W'(1);
          end
        end
      end
      LOCKED: begin
        if (h_err_c || v_err_c) begin
          state_nxt = ACQUIRE;
          good_nxt  = '0;
          dirty_nxt = 1'b1;
        end
      end
      default: state_nxt = UNLOCKED;
    endcase
    if (timeout_c) begin
      state_nxt  = UNLOCKED;
      good_nxt   = '0;
      dirty_nxt  = 1'b0;
      seen_h_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= UNLOCKED;
      good_frames <= '0;
      dirty       <= 1'b0;
      seen_h      <= 1'b0;
      to_cnt      <= '0;
      colPos      <= '0;
      rowPos      <= '0;
      visible     <= 1'b0;
      frame_start <= 1'b0;
      h_err       <= 1'b0;
      v_err       <= 1'b0;
      err_count   <= '0;
    end else begin
      state       <= state_nxt;
      good_frames <= good_nxt;
      dirty       <= dirty_nxt;
      seen_h      <= seen_h_nxt;
      if (h_assert_c) begin
        to_cnt <= '0;
      end else if (to_cnt != TO_W'(TIMEOUT - 1)) begin
        to_cnt <= to_cnt + TO_W'(1);
      end
      colPos      <= col_nxt_c;
      rowPos      <= row_nxt_c;
      visible     <= (state_nxt == LOCKED) && (col_nxt_c < POS_W'(H_VISIBLE)) &&
                     (row_nxt_c < POS_W'(V_VISIBLE));
      frame_start <= (state_nxt == LOCKED) && (col_nxt_c == '0) && (row_nxt_c == '0);
      h_err       <= h_err_c;
      v_err       <= v_err_c;
      // One count per error cycle, saturating.
      if ((h_err || v_err) && (err_count != '1)) begin
        err_count <= err_count + ERR_W'(1);
      end
    end
  end

  assign locked = (state == LOCKED);

endmodule

// File: tb/tb_vga_sync_monitor.sv
// Scoreboard bench for vga_sync_monitor on a reduced geometry driven by a small timing generator.
module tb_vga_sync_monitor;

  localparam int HV = 16, HFP = 2, HS = 4, HBP = 3;
  localparam int VV = 8,  VFP = 2, VS = 2, VBP = 3;
  localparam int HT = HV + HFP + HS + HBP;
  localparam int VT = VV + VFP + VS + VBP;
  localparam int H_SS = HV + HFP, H_SE = H_SS + HS;
  localparam int V_SS = VV + VFP, V_SE = V_SS + VS;
  localparam int FRAME = HT * VT;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       HSYNC, VSYNC;
  logic [9:0] colPos, rowPos;
  logic       visible, locked, frame_start, h_err, v_err;
  logic [7:0] err_count;

  always #5 clk = ~clk;

  vga_sync_monitor #(
    .H_VISIBLE(HV), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_VISIBLE(VV), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
    .SYNC_ACTIVE_LOW(1'b1), .LOCK_FRAMES(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .HSYNC(HSYNC), .VSYNC(VSYNC),
    .colPos(colPos), .rowPos(rowPos), .visible(visible), .locked(locked),
    .frame_start(frame_start), .h_err(h_err), .v_err(v_err), .err_count(err_count)
  );

  typedef struct {
    bit pos;
    bit err;
    bit lck_en;
    int col;
    int row;
    bit herr;
    bit verr;
    bit lck;
  } exp_t;

  exp_t sb[$];
  int n_checks = 0;
  int n_pass = 0;
  int gc, gr, relock_cnt, vis_cnt, fs_cnt;
  bit exp_lck, pos_en, pos_arm, err_en, lck_en;
  bit stall_req, stall_pend, wide_req, wide_act, h_mask, toggle_h, tog;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_colPos"}, int'(colPos), 0);
    check({tag, "_rowPos"}, int'(rowPos), 0);
    check({tag, "_visible"}, int'(visible), 0);
    check({tag, "_locked"}, int'(locked), 0);
    check({tag, "_frame_start"}, int'(frame_start), 0);
    check({tag, "_h_err"}, int'(h_err), 0);
    check({tag, "_v_err"}, int'(v_err), 0);
    check({tag, "_err_count"}, int'(err_count), 0);
  endtask

  // One pixel: compare the output due for the pixel driven two cycles ago, then drive the next.
  task automatic step();
    exp_t e;
    bit hs, vs, herr_e, verr_e;
    @(negedge clk);
    if (sb.size() == 2) begin
      e = sb.pop_front();
      if (e.pos) begin
        check("colPos", int'(colPos), e.col);
        check("rowPos", int'(rowPos), e.row);
      end
      if (e.err) begin
        check("h_err", int'(h_err), int'(e.herr));
        check("v_err", int'(v_err), int'(e.verr));
      end
      if (e.lck_en) begin
        check("locked", int'(locked), int'(e.lck));
        if (e.pos) begin
          check("visible", int'(visible), int'(e.lck && e.col < HV && e.row < VV));
          check("frame_start", int'(frame_start), int'(e.lck && e.col == 0 && e.row == 0));
        end
      end
    end
    if (visible) vis_cnt++;
    if (frame_start) fs_cnt++;

    herr_e = 1'b0;
    verr_e = 1'b0;
    if (stall_pend && gc == H_SS) begin
      herr_e = 1'b1;
      stall_pend = 1'b0;
    end
    hs = (gc >= H_SS) && (gc < H_SE) && !h_mask;
    if (toggle_h) begin
      hs = tog;
      tog = !tog;
    end
    if (wide_req && gc == 0 && gr == V_SS) begin
      wide_act = 1'b1;
      wide_req = 1'b0;
    end
    vs = (gr >= V_SS) && (gr < (wide_act ? V_SE + 1 : V_SE));
    if (wide_act && gc == 0 && gr == V_SE + 1) begin
      verr_e = 1'b1;
      wide_act = 1'b0;
    end
    if (gc == 0 && gr == V_SS) begin
      relock_cnt++;
      if (pos_arm) begin
        pos_en = 1'b1;
        pos_arm = 1'b0;
      end
      if (relock_cnt >= 3) exp_lck = 1'b1;
    end
    if (herr_e || verr_e) begin
      exp_lck = 1'b0;
      relock_cnt = 0;
    end
    HSYNC = !hs;
    VSYNC = !vs;
    e = '{pos: pos_en && !stall_pend, err: err_en, lck_en: lck_en, col: gc, row: gr,
          herr: herr_e, verr: verr_e, lck: exp_lck};
    sb.push_back(e);
    if (stall_req && gc == 5) begin
      stall_req = 1'b0;
      stall_pend = 1'b1;
    end else begin
      gc++;
      if (gc == HT) begin
        gc = 0;
        gr = (gr + 1) % VT;
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    HSYNC = 1'b1;
    VSYNC = 1'b1;
    gc = 0; gr = 0; relock_cnt = 0; vis_cnt = 0; fs_cnt = 0;
    exp_lck = 0; pos_en = 0; pos_arm = 1; err_en = 1; lck_en = 1;
    stall_req = 0; stall_pend = 0; wide_req = 0; wide_act = 0;
    h_mask = 0; toggle_h = 0; tog = 0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;

    // Clean frames: lock on the third VSYNC edge, then one fully locked frame.
    repeat (3 * FRAME) step();
    vis_cnt = 0;
    fs_cnt = 0;
    repeat (FRAME) step();
    check("visible_per_frame", vis_cnt, HV * VV);
    check("frame_start_per_frame", fs_cnt, 1);

    // One line lengthened by a cycle.
    stall_req = 1'b1;
    repeat (3 * FRAME) step();
    check("err_count_after_long_line", int'(err_count), 1);
    check("relocked_after_long_line", int'(locked), 1);

    // One VSYNC pulse widened to three lines.
    wide_req = 1'b1;
    repeat (FRAME) step();
    check("err_count_after_wide_vsync", int'(err_count), 2);
    check("unlocked_after_wide_vsync", int'(locked), 0);
    repeat (3 * FRAME) step();
    check("relocked_after_wide_vsync", int'(locked), 1);

    // HSYNC held deasserted well past the timeout.
    lck_en = 1'b0;
    h_mask = 1'b1;
    repeat (3 * HT) step();
    h_mask = 1'b0;
    check("timeout_locked", int'(locked), 0);
    check("timeout_visible", int'(visible), 0);
    repeat (2 * FRAME) step();

    // Chattering HSYNC produces far more than 255 error cycles.
    err_en = 1'b0;
    pos_en = 1'b0;
    toggle_h = 1'b1;
    repeat (600) step();
    toggle_h = 1'b0;
    check("err_count_saturated", int'(err_count), 255);

    // Mid-frame reset clears every output by the next cycle.
    rst_n = 1'b0;
    sb.delete();
    @(negedge clk);
    check_all_zero("mid_reset");
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
